hoplite_fox_nic: RTL

- Network interface between a PicoRV32 Fox node's memory-mapped field registers and its Hoplite router port.
- TX path: collects per-field writes from the processor, assembles one flit, and injects it with a valid/ready handshake.
- RX path: buffers flits ejected by the router in a small FIFO and presents the head flit's fields to the processor until it is popped.

---
 rtl/hoplite_fox_pkg.sv | 71 +++++++
 rtl/hoplite_fox.sv | 15 +
 rtl/hoplite_nic_rx_fifo.sv | 62 ++++++
 rtl/hoplite_fox_nic.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/hoplite_fox_pkg.sv
// Shared widths, flit layout and TX state encoding for the Hoplite Fox NIC.
// Flit layout MSB->LSB: x, y, multicast_group, done, result, matrix_type, matrix_x, matrix_y, element.
package hoplite_fox_pkg;

  localparam int COORD_BITS           = 1;
  localparam int MULTICAST_GROUP_BITS = 1;
  localparam int MATRIX_TYPE_BITS     = 1;
  localparam int MATRIX_COORD_BITS    = 8;
  localparam int MATRIX_ELEMENT_BITS  = 32;
  localparam int FLIT_BITS = 2*COORD_BITS + MULTICAST_GROUP_BITS + 2 + MATRIX_TYPE_BITS
                           + 2*MATRIX_COORD_BITS + MATRIX_ELEMENT_BITS;

  localparam int ELEM_LSB   = 0;
  localparam int MY_LSB     = ELEM_LSB + MATRIX_ELEMENT_BITS;
  localparam int MX_LSB     = MY_LSB + MATRIX_COORD_BITS;
  localparam int MT_LSB     = MX_LSB + MATRIX_COORD_BITS;
  localparam int RESULT_LSB = MT_LSB + MATRIX_TYPE_BITS;
  localparam int DONE_LSB   = RESULT_LSB + 1;
  localparam int MC_LSB     = DONE_LSB + 1;
  localparam int Y_LSB      = MC_LSB + MULTICAST_GROUP_BITS;
  localparam int X_LSB      = Y_LSB + COORD_BITS;

  typedef logic [FLIT_BITS-1:0] flit_t;

  typedef struct packed {
    logic [COORD_BITS-1:0]           x;
    logic [COORD_BITS-1:0]           y;
    logic [MULTICAST_GROUP_BITS-1:0] mc;
    logic                            done;
    logic                            result;
    logic [MATRIX_TYPE_BITS-1:0]     mtype;
    logic [MATRIX_COORD_BITS-1:0]    mx;
    logic [MATRIX_COORD_BITS-1:0]    my;
    logic [MATRIX_ELEMENT_BITS-1:0]  elem;
  } flit_fields_t;

  typedef enum logic {
    TX_IDLE    = 1'b0,
    TX_PENDING = 1'b1
  } tx_state_t;

  function automatic flit_t pack_flit(input flit_fields_t f);
    flit_t v;
    v = '0;
    v[X_LSB +: COORD_BITS]              = f.x;
    v[Y_LSB +: COORD_BITS]              = f.y;
    v[MC_LSB +: MULTICAST_GROUP_BITS]   = f.mc;
    v[DONE_LSB]                         = f.done;
    v[RESULT_LSB]                       = f.result;
    v[MT_LSB +: MATRIX_TYPE_BITS]       = f.mtype;
    v[MX_LSB +: MATRIX_COORD_BITS]      = f.mx;
    v[MY_LSB +: MATRIX_COORD_BITS]      = f.my;
    v[ELEM_LSB +: MATRIX_ELEMENT_BITS]  = f.elem;
    return v;
  endfunction

  function automatic flit_fields_t unpack_flit(input flit_t v);
    flit_fields_t f;
    f.x      = v[X_LSB +: COORD_BITS];
    f.y      = v[Y_LSB +: COORD_BITS];
    f.mc     = v[MC_LSB +: MULTICAST_GROUP_BITS];
    f.done   = v[DONE_LSB];
    f.result = v[RESULT_LSB];
    f.mtype  = v[MT_LSB +: MATRIX_TYPE_BITS];
    f.mx     = v[MX_LSB +: MATRIX_COORD_BITS];
    f.my     = v[MY_LSB +: MATRIX_COORD_BITS];
    f.elem   = v[ELEM_LSB +: MATRIX_ELEMENT_BITS];
    return f;
  endfunction

endpackage

// File: rtl/hoplite_fox.sv
// Sticky error-flag helper shared by the Hoplite Fox NIC top level (hoplite_fox_nic.sv).
// The flag sets on a single-cycle strobe and clears only on synchronous reset.
module hoplite_fox_sticky (
  input  logic clk,
  input  logic reset_n,
  input  logic set,
  output logic flag
);

  always_ff @(posedge clk) begin
    if (!reset_n) flag <= 1'b0;
    else if (set) flag <= 1'b1;
  end

endmodule

// File: rtl/hoplite_nic_rx_fifo.sv
// RX buffer: DEPTH-entry circular FIFO feeding a first-word-fall-through head register.
// A push into a full FIFO is accepted only when the head reloads from it on the same edge.
module hoplite_nic_rx_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         head_valid,
  output logic         available,
  output logic         push_accept,
  output logic         drop
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          fifo_empty;
  logic          fifo_full;
  logic          fifo_pop;

  assign fifo_empty  = (count == '0);
  assign fifo_full   = (count == CW'(DEPTH));
  assign fifo_pop    = !fifo_empty && (!head_valid || pop);
  assign push_accept = push && (!fifo_full || fifo_pop);
  assign drop        = push && !push_accept;
  assign available   = head_valid || !fifo_empty;

  always_ff @(posedge clk) begin
    if (push_accept) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
      head_data  <= '0;
    end else begin
      if (push_accept) wr_ptr <= wr_ptr + PW'(1);
      // Pointers wrap naturally because DEPTH is a power of two.
      if (fifo_pop) begin
        rd_ptr     <= rd_ptr + PW'(1);
        head_data  <= mem[rd_ptr];
        head_valid <= 1'b1;
      end else if (pop) begin
        head_valid <= 1'b0;
      end
      count <= count + CW'(push_accept) - CW'(fifo_pop);
    end
  end

endmodule

// File: rtl/hoplite_fox_nic.sv
// Hoplite Fox NIC: field-register TX assembly with valid/ready injection, FWFT RX buffering.
// Optional HOPLITE_NIC_STATS_EN adds 32-bit tx/rx/drop flit counters.
module hoplite_fox_nic
  import hoplite_fox_pkg::*;
#(
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [COORD_BITS-1:0]           tx_x_coord,
  input  logic [COORD_BITS-1:0]           tx_y_coord,
  input  logic [MULTICAST_GROUP_BITS-1:0] tx_multicast_group,
  input  logic                            tx_done_flag,
  input  logic                            tx_result_flag,
  input  logic [MATRIX_TYPE_BITS-1:0]     tx_matrix_type,
  input  logic [MATRIX_COORD_BITS-1:0]    tx_matrix_x_coord,
  input  logic [MATRIX_COORD_BITS-1:0]    tx_matrix_y_coord,
  input  logic [MATRIX_ELEMENT_BITS-1:0]  tx_matrix_element,
  input  logic                            tx_x_coord_valid,
  input  logic                            tx_y_coord_valid,
  input  logic                            tx_multicast_group_valid,
  input  logic                            tx_done_flag_valid,
  input  logic                            tx_result_flag_valid,
  input  logic                            tx_matrix_type_valid,
  input  logic                            tx_matrix_x_coord_valid,
  input  logic                            tx_matrix_y_coord_valid,
  input  logic                            tx_matrix_element_valid,
  input  logic                            tx_packet_complete,
  output logic                            tx_ready,
  output logic [MULTICAST_GROUP_BITS-1:0] rx_multicast_group,
  output logic                            rx_done_flag,
  output logic                            rx_result_flag,
  output logic [MATRIX_TYPE_BITS-1:0]     rx_matrix_type,
  output logic [MATRIX_COORD_BITS-1:0]    rx_matrix_x_coord,
  output logic [MATRIX_COORD_BITS-1:0]    rx_matrix_y_coord,
  output logic [MATRIX_ELEMENT_BITS-1:0]  rx_matrix_element,
  output logic                            rx_valid,
  output logic                            rx_available,
  input  logic                            rx_read,
  output logic [FLIT_BITS-1:0]            router_in_flit,
  output logic                            router_in_valid,
  input  logic                            router_in_ready,
  input  logic [FLIT_BITS-1:0]            router_out_flit,
  input  logic                            router_out_valid,
  output logic                            tx_overflow,
  output logic                            rx_overflow,
  output tx_state_t                       tx_state
`ifdef HOPLITE_NIC_STATS_EN
  ,
  output logic [31:0]                     tx_flit_count,
  output logic [31:0]                     rx_flit_count,
  output logic [31:0]                     rx_drop_count
`endif
);

  // Handshake: a flit transfers on every rising edge where router_in_valid && router_in_ready;
  // router_in_valid and router_in_flit stay stable until then. Ejection has no backpressure.

  flit_fields_t stage_q;
  flit_fields_t stage_d;
  tx_state_t    state_d;
  logic         flit_load;
  logic         tx_overflow_set;

  always_comb begin
    stage_d = stage_q;
    if (tx_x_coord_valid)         stage_d.x      = tx_x_coord;
    if (tx_y_coord_valid)         stage_d.y      = tx_y_coord;
    if (tx_multicast_group_valid) stage_d.mc     = tx_multicast_group;
    if (tx_done_flag_valid)       stage_d.done   = tx_done_flag;
    if (tx_result_flag_valid)     stage_d.result = tx_result_flag;
    if (tx_matrix_type_valid)     stage_d.mtype  = tx_matrix_type;
    if (tx_matrix_x_coord_valid)  stage_d.mx     = tx_matrix_x_coord;
    if (tx_matrix_y_coord_valid)  stage_d.my     = tx_matrix_y_coord;
    if (tx_matrix_element_valid)  stage_d.elem   = tx_matrix_element;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) tx_state <= TX_IDLE;
    else          tx_state <= state_d;
  end

  always_comb begin
    state_d         = tx_state;
    flit_load       = 1'b0;
    tx_overflow_set = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (tx_packet_complete) begin
          flit_load = 1'b1;
          state_d   = TX_PENDING;
        end
      end
      TX_PENDING: begin
        tx_overflow_set = tx_packet_complete;
        if (router_in_ready) state_d = TX_IDLE;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  assign router_in_valid = (tx_state == TX_PENDING);

  // tx_ready is registered so it stays low while reset is held.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stage_q        <= '0;
      router_in_flit <= '0;
      tx_ready       <= 1'b0;
    end else begin
      stage_q  <= stage_d;
      tx_ready <= (state_d == TX_IDLE);
      if (flit_load) router_in_flit <= pack_flit(stage_d);
    end
  end

  hoplite_fox_sticky u_tx_ovf (
    .clk     (clk),
    .reset_n (reset_n),
    .set     (tx_overflow_set),
    .flag    (tx_overflow)
  );

  flit_t        head_flit;
  flit_fields_t head_fields;
  logic         fifo_push_accept;
  logic         fifo_drop;
  logic         unused_rx_coords;

  hoplite_nic_rx_fifo #(
    .W     (FLIT_BITS),
    .DEPTH (RX_FIFO_DEPTH)
  ) u_rx_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push        (router_out_valid),
    .push_data   (router_out_flit),
    .pop         (rx_read),
    .head_data   (head_flit),
    .head_valid  (rx_valid),
    .available   (rx_available),
    .push_accept (fifo_push_accept),
    .drop        (fifo_drop)
  );

  hoplite_fox_sticky u_rx_ovf (
    .clk     (clk),
    .reset_n (reset_n),
    .set     (fifo_drop),
    .flag    (rx_overflow)
  );

  assign head_fields        = unpack_flit(head_flit);
  assign rx_multicast_group = head_fields.mc;
  assign rx_done_flag       = head_fields.done;
  assign rx_result_flag     = head_fields.result;
  assign rx_matrix_type     = head_fields.mtype;
  assign rx_matrix_x_coord  = head_fields.mx;
  assign rx_matrix_y_coord  = head_fields.my;
  assign rx_matrix_element  = head_fields.elem;
  // Routing coordinates are consumed by the router, not the processor.
  assign unused_rx_coords   = ^{head_fields.x, head_fields.y};

`ifdef HOPLITE_NIC_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_flit_count <= '0;
      rx_flit_count <= '0;
      rx_drop_count <= '0;
    end else begin
      if (router_in_valid && router_in_ready) tx_flit_count <= tx_flit_count + 32'd1;
      if (fifo_push_accept)                   rx_flit_count <= rx_flit_count + 32'd1;
      if (fifo_drop)                          rx_drop_count <= rx_drop_count + 32'd1;
    end
  end
`else
  logic unused_stats;
  assign unused_stats = fifo_push_accept;
`endif

endmodule
